// File: rtl/pc_gen.sv
// pc_gen: program-counter / fetch-request generator for the IF stage.
// Issues one instruction-fetch address per accepted valid/ready handshake.
// The address steps by INST_BYTES. Branch and trap redirects replace the
// sequential address. A redirect that arrives while the current request is
// still unaccepted is parked in a one-entry buffer until the handshake
// completes.
module pc_gen #(
  parameter int unsigned       ADDR_W     = 32,
  parameter int unsigned       INST_BYTES = 4,
  parameter logic [ADDR_W-1:0] RESET_VEC  = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall_i,
  input  logic              br_valid_i,
  input  logic [ADDR_W-1:0] br_target_i,
  input  logic              trap_valid_i,
  input  logic [ADDR_W-1:0] trap_vec_i,
  input  logic              fetch_ready_i,
  output logic [ADDR_W-1:0] pc_o,
  output logic              fetch_valid_o,
  output logic              redirect_pending_o
);

  localparam logic [ADDR_W-1:0] STEP       = ADDR_W'(INST_BYTES);
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ~(ADDR_W'(INST_BYTES - 1));

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    HOLD
  } state_t;

  state_t            state;
  logic              pend_trap;   // buffered redirect is a trap (else a branch)
  logic [ADDR_W-1:0] pend_tgt;    // buffered, already-aligned redirect target

  logic              accept;
  logic              new_any;
  logic [ADDR_W-1:0] new_tgt;
  logic              take_new;
  logic              sel_valid;
  logic              sel_trap;
  logic [ADDR_W-1:0] sel_tgt;

  assign accept = fetch_valid_o && fetch_ready_i;

  // Pick the redirect that wins this cycle: a new trap beats everything, a
  // new branch beats a buffered branch, and a buffered trap beats a new branch.
  always_comb begin
    // NOTE: every always_comb output gets a default first so that no path
    // leaves it unassigned, which would otherwise infer a latch.
    new_any   = trap_valid_i || br_valid_i;
    new_tgt   = (trap_valid_i ? trap_vec_i : br_target_i) & ALIGN_MASK;
    take_new  = trap_valid_i || (br_valid_i && !(redirect_pending_o && pend_trap));
    sel_valid = new_any || redirect_pending_o;
    sel_trap  = pend_trap;
    sel_tgt   = pend_tgt;
    if (take_new) begin
      sel_trap = trap_valid_i;
      sel_tgt  = new_tgt;
    end
  end

  // Fetch state machine: PC, request valid and the pending-redirect buffer.
  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    if (rst) begin
      state              <= IDLE;
      pc_o               <= RESET_VEC;
      fetch_valid_o      <= 1'b0;
      redirect_pending_o <= 1'b0;
      pend_trap          <= 1'b0;
      pend_tgt           <= '0;
    end else begin
      case (state)
        IDLE: begin
          // First request goes out at RESET_VEC; redirects are ignored here.
          state         <= RUN;
          fetch_valid_o <= 1'b1;
        end
        RUN, HOLD: begin
          if (sel_valid) begin
            if (accept) begin
              // Redirect transfers on the handshake, independent of stall.
              pc_o               <= sel_tgt;
              redirect_pending_o <= 1'b0;
              pend_trap          <= 1'b0;
              state              <= RUN;
            end else begin
              redirect_pending_o <= 1'b1;
              pend_trap          <= sel_trap;
              pend_tgt           <= sel_tgt;
              state              <= HOLD;
            end
          end else if (accept && !stall_i) begin
            // Wraps silently modulo 2^ADDR_W.
            pc_o <= pc_o + STEP;
          end
        end
        default: begin
          state         <= IDLE;
          fetch_valid_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pc_gen.sv
// tb_pc_gen: self-checking bench for pc_gen.
// It runs a directed vector table and a randomized run checked against a
// reference model on a 32-bit instance. It also runs a hand-written wrap and
// alignment sequence on a 16-bit, 2-byte-stride instance.
module tb_pc_gen;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  // 32-bit instance: ADDR_W=32, INST_BYTES=4, RESET_VEC=0x100
  logic        rst, stall, br, trap, ready;
  logic [31:0] br_tgt, trap_vec;
  logic [31:0] pc;
  logic        valid, pend;

  pc_gen #(.ADDR_W(32), .INST_BYTES(4), .RESET_VEC(32'h100)) dut (
    .clk(clk), .rst(rst), .stall_i(stall),
    .br_valid_i(br), .br_target_i(br_tgt),
    .trap_valid_i(trap), .trap_vec_i(trap_vec),
    .fetch_ready_i(ready),
    .pc_o(pc), .fetch_valid_o(valid), .redirect_pending_o(pend)
  );

  // 16-bit instance: ADDR_W=16, INST_BYTES=2, RESET_VEC=0xFFFC
  logic        rst16, stall16, br16, trap16, ready16;
  logic [15:0] br_tgt16, trap_vec16;
  logic [15:0] pc16;
  logic        valid16, pend16;

  pc_gen #(.ADDR_W(16), .INST_BYTES(2), .RESET_VEC(16'hFFFC)) dut16 (
    .clk(clk), .rst(rst16), .stall_i(stall16),
    .br_valid_i(br16), .br_target_i(br_tgt16),
    .trap_valid_i(trap16), .trap_vec_i(trap_vec16),
    .fetch_ready_i(ready16),
    .pc_o(pc16), .fetch_valid_o(valid16), .redirect_pending_o(pend16)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Directed vector table: inputs applied before an edge, outputs after it.
  typedef struct {
    logic        rst, stall, br, trap, ready;
    logic [31:0] br_tgt, trap_vec;
    logic [31:0] exp_pc;
    logic        exp_valid, exp_pend;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic r, input logic s, input logic b, input logic [31:0] bt,
                              input logic t, input logic [31:0] tv, input logic rd,
                              input logic [31:0] epc, input logic ev, input logic ep);
    vec_t v;
    v.rst = r; v.stall = s; v.br = b; v.br_tgt = bt; v.trap = t; v.trap_vec = tv;
    v.ready = rd; v.exp_pc = epc; v.exp_valid = ev; v.exp_pend = ep;
    return v;
  endfunction

  // Reference model state, kept in spec terms: "started" means a request is
  // outstanding, and the pending redirect carries a priority rank
  // (2 = trap, 1 = branch, 0 = none).
  logic [31:0] m_pc;
  logic        m_started;
  int          m_pend_rank;
  logic [31:0] m_pend_tgt;

  task automatic model_step(input logic r, input logic s, input logic b, input logic [31:0] bt,
                            input logic t, input logic [31:0] tv, input logic rd);
    int          new_rank;
    logic [31:0] new_tgt;
    int          win_rank;
    logic [31:0] win_tgt;
    if (r) begin
      m_pc = 32'h100; m_started = 1'b0; m_pend_rank = 0; m_pend_tgt = '0;
      return;
    end
    if (!m_started) begin
      m_started = 1'b1;
      return;
    end
    new_rank = t ? 2 : (b ? 1 : 0);
    new_tgt  = (t ? tv : bt) & ~32'd3;
    // The newest request of at least equal rank replaces the buffered one.
    win_rank = m_pend_rank;
    win_tgt  = m_pend_tgt;
    if (new_rank > 0 && new_rank >= m_pend_rank) begin
      win_rank = new_rank;
      win_tgt  = new_tgt;
    end
    if (win_rank > 0) begin
      if (rd) begin
        m_pc = win_tgt; m_pend_rank = 0;
      end else begin
        m_pend_rank = win_rank; m_pend_tgt = win_tgt;
      end
    end else if (rd && !s) begin
      m_pc = m_pc + 32'd4;
    end
  endtask

  task automatic drive(input vec_t v);
    rst = v.rst; stall = v.stall; br = v.br; br_tgt = v.br_tgt;
    trap = v.trap; trap_vec = v.trap_vec; ready = v.ready;
  endtask

  task automatic step16(input logic r, input logic b, input logic [15:0] bt, input logic rd);
    rst16 = r; br16 = b; br_tgt16 = bt; ready16 = rd;
    @(posedge clk); #1;
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; br = 1'b0; trap = 1'b0; ready = 1'b0;
    br_tgt = '0; trap_vec = '0;
    rst16 = 1'b1; stall16 = 1'b0; br16 = 1'b0; trap16 = 1'b0; ready16 = 1'b0;
    br_tgt16 = '0; trap_vec16 = '0;

    //             rst stl br  br_tgt     tr  trap_vec  rdy  exp_pc     v  p
    vecs.push_back(mk(1, 0, 0, 32'h0,     0, 32'h0,   0, 32'h100,  0, 0)); // reset
    vecs.push_back(mk(0, 0, 0, 32'h0,     0, 32'h0,   1, 32'h100,  1, 0)); // first req = RESET_VEC
    vecs.push_back(mk(0, 0, 0, 32'h0,     0, 32'h0,   1, 32'h104,  1, 0));
    vecs.push_back(mk(0, 0, 0, 32'h0,     0, 32'h0,   1, 32'h108,  1, 0));
    vecs.push_back(mk(0, 0, 0, 32'h0,     0, 32'h0,   0, 32'h108,  1, 0)); // back-pressure x3
    vecs.push_back(mk(0, 0, 0, 32'h0,     0, 32'h0,   0, 32'h108,  1, 0));
    vecs.push_back(mk(0, 0, 0, 32'h0,     0, 32'h0,   0, 32'h108,  1, 0));
    vecs.push_back(mk(0, 0, 0, 32'h0,     0, 32'h0,   1, 32'h10C,  1, 0));
    vecs.push_back(mk(0, 1, 0, 32'h0,     0, 32'h0,   1, 32'h10C,  1, 0)); // stall + accept holds
    vecs.push_back(mk(0, 1, 0, 32'h0,     0, 32'h0,   1, 32'h10C,  1, 0));
    vecs.push_back(mk(0, 0, 1, 32'h2002,  0, 32'h0,   0, 32'h10C,  1, 1)); // branch while blocked
    vecs.push_back(mk(0, 0, 0, 32'h0,     0, 32'h0,   1, 32'h2000, 1, 0)); // aligned target
    vecs.push_back(mk(0, 0, 1, 32'h400,   0, 32'h0,   0, 32'h2000, 1, 1)); // branch pends
    vecs.push_back(mk(0, 0, 0, 32'h0,     1, 32'h80,  0, 32'h2000, 1, 1)); // trap overwrites
    vecs.push_back(mk(0, 0, 1, 32'h500,   0, 32'h0,   0, 32'h2000, 1, 1)); // branch cannot
    vecs.push_back(mk(0, 0, 0, 32'h0,     0, 32'h0,   1, 32'h80,   1, 0));
    vecs.push_back(mk(0, 0, 0, 32'h0,     0, 32'h0,   1, 32'h84,   1, 0));
    vecs.push_back(mk(0, 0, 1, 32'h400,   1, 32'h80,  1, 32'h80,   1, 0)); // same-cycle: trap wins
    vecs.push_back(mk(0, 1, 1, 32'h600,   0, 32'h0,   1, 32'h600,  1, 0)); // redirect ignores stall
    vecs.push_back(mk(0, 0, 1, 32'h700,   0, 32'h0,   0, 32'h600,  1, 1)); // HOLD
    vecs.push_back(mk(1, 0, 0, 32'h0,     0, 32'h0,   1, 32'h100,  0, 0)); // reset drops pending
    vecs.push_back(mk(0, 0, 1, 32'h900,   0, 32'h0,   0, 32'h100,  1, 0)); // IDLE ignores branch
    vecs.push_back(mk(0, 0, 0, 32'h0,     0, 32'h0,   1, 32'h104,  1, 0));
    vecs.push_back(mk(0, 0, 1, 32'h800,   0, 32'h0,   0, 32'h104,  1, 1));
    vecs.push_back(mk(0, 1, 0, 32'h0,     0, 32'h0,   1, 32'h800,  1, 0)); // HOLD transfer under stall

    foreach (vecs[i]) begin
      drive(vecs[i]);
      @(posedge clk); #1;
      check($sformatf("vec%0d pc", i), pc, vecs[i].exp_pc);
      check($sformatf("vec%0d valid", i), {31'b0, valid}, {31'b0, vecs[i].exp_valid});
      check($sformatf("vec%0d pend", i), {31'b0, pend}, {31'b0, vecs[i].exp_pend});
    end

    // Randomized run against the reference model, starting from a reset.
    model_step(1'b1, 1'b0, 1'b0, '0, 1'b0, '0, 1'b0);
    rst = 1'b1; br = 1'b0; trap = 1'b0;
    @(posedge clk); #1;
    for (int n = 0; n < 400; n++) begin
      rst      = ($urandom_range(0, 99) < 2);
      stall    = ($urandom_range(0, 99) < 30);
      br       = ($urandom_range(0, 99) < 20);
      trap     = ($urandom_range(0, 99) < 8);
      ready    = ($urandom_range(0, 99) < 60);
      br_tgt   = $urandom();
      trap_vec = $urandom();
      if ($urandom_range(0, 9) == 0) br_tgt = 32'hFFFF_FFFC;
      model_step(rst, stall, br, br_tgt, trap, trap_vec, ready);
      @(posedge clk); #1;
      check($sformatf("rnd%0d pc", n), pc, m_pc);
      check($sformatf("rnd%0d valid", n), {31'b0, valid}, {31'b0, m_started});
      check($sformatf("rnd%0d pend", n), {31'b0, pend}, {31'b0, (m_pend_rank != 0)});
    end

    // 16-bit, stride 2: wrap past 0xFFFE, target alignment, reset in HOLD.
    step16(1'b1, 1'b0, 16'h0, 1'b0);
    check("w16 reset pc", {16'b0, pc16}, 32'hFFFC);
    check("w16 reset valid", {31'b0, valid16}, 32'h0);
    step16(1'b0, 1'b0, 16'h0, 1'b1);
    check("w16 first pc", {16'b0, pc16}, 32'hFFFC);
    step16(1'b0, 1'b0, 16'h0, 1'b1);
    check("w16 pc FFFE", {16'b0, pc16}, 32'hFFFE);
    step16(1'b0, 1'b0, 16'h0, 1'b1);
    check("w16 wrap", {16'b0, pc16}, 32'h0000);
    step16(1'b0, 1'b0, 16'h0, 1'b1);
    check("w16 after wrap", {16'b0, pc16}, 32'h0002);
    step16(1'b0, 1'b1, 16'h1235, 1'b1);
    check("w16 align", {16'b0, pc16}, 32'h1234);
    step16(1'b0, 1'b1, 16'h3333, 1'b0);
    check("w16 hold pend", {31'b0, pend16}, 32'h1);
    check("w16 hold pc", {16'b0, pc16}, 32'h1234);
    step16(1'b1, 1'b0, 16'h0, 1'b1);
    check("w16 rst pc", {16'b0, pc16}, 32'hFFFC);
    check("w16 rst pend", {31'b0, pend16}, 32'h0);
    check("w16 rst valid", {31'b0, valid16}, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
